fpu_add_issuer: RTL and testbench

Initiator-side driver for the fpu_add_RTL adder. Buffers operand pairs from an upstream valid/ready stream and issues each pair to the adder as a one-cycle valid pulse. It then waits for the adder's ready, captures the result, and presents it downstream on a valid/ready output register. It sits between the instruction/operand path and fpu_add_RTL, which is otherwise driven only by benches.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_op_fifo.sv | 54 +++++
 rtl/fpu_add_issuer.sv | 137 +++++++++++++
 tb/tb_fpu_add_issuer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu_add_RTL initiator path.
package fpu_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp_pair_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} issuer_state_t;

    localparam fp32_t FP32_QNAN = 32'h7fc00000;

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous FIFO of operand pairs; DEPTH must be a power of two so the pointers wrap freely.
module fpu_op_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fp_pair_t                     wdata,
    input  logic                         pop,
    output fp_pair_t                     rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fp_pair_t        mem [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

    assign rdata = mem[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/fpu_add_issuer.sv
// Buffers operand pairs, issues them one at a time to fpu_add_RTL and registers each result
// (or a quiet-NaN timeout marker) for a downstream valid/ready consumer.
module fpu_add_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic [31:0]   fpu_din1,
    output logic [31:0]   fpu_din2,
    output logic          fpu_valid,
    input  logic [31:0]   fpu_result,
    input  logic          fpu_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_timeout,
    output logic          busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    issuer_state_t                   state_q, state_d;
    fp32_t                           din1_q, din1_d;
    fp32_t                           din2_q, din2_d;
    logic                            fpu_valid_q, fpu_valid_d;
    logic                            out_valid_q, out_valid_d;
    fp32_t                           out_result_q, out_result_d;
    logic                            out_timeout_q, out_timeout_d;
    logic [CW-1:0]                   cnt_q, cnt_d;

    fp_pair_t                        head;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [$clog2(DEPTH+1)-1:0]      fifo_count;
    logic                            pop;

    fpu_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && !fifo_full),
        .wdata ('{a: in_a, b: in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        din1_d        = din1_q;
        din2_d        = din2_q;
        fpu_valid_d   = 1'b0;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_timeout_d = out_timeout_q;
        cnt_d         = cnt_q;
        pop           = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        unique case (state_q)
            // Holding off while a result is pending keeps at most one op in flight.
            IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    state_d     = ISSUE;
                    din1_d      = head.a;
                    din2_d      = head.b;
                    fpu_valid_d = 1'b1;
                    pop         = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_d = cnt_q + 1'b1;
                if (fpu_ready) begin
                    out_result_d  = fpu_result;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = GAP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    out_result_d  = FP32_QNAN;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            din1_q        <= '0;
            din2_q        <= '0;
            fpu_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            din1_q        <= din1_d;
            din2_q        <= din2_d;
            fpu_valid_q   <= fpu_valid_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_timeout_q <= out_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);
    assign fpu_din1    = din1_q;
    assign fpu_din2    = din2_q;
    assign fpu_valid   = fpu_valid_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_fpu_add_issuer.sv
// Bench for fpu_add_issuer: transaction-level model (pending-op queue, adder responder,
// expected-result queue with due cycles) checked every cycle, plus directed literal checks.
module tb_fpu_add_issuer;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 64;
    localparam int LAT   = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } op_t;

    typedef struct packed {
        logic [31:0] r;
        logic        to;
        int          due;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_sum = '0;
    logic [31:0] fpu_din1;
    logic [31:0] fpu_din2;
    logic        fpu_valid;
    logic [31:0] fpu_result = '0;
    logic        fpu_ready = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_timeout;
    logic        busy;

    op_t         exp_ops[$];
    res_t        exp_res[$];
    logic [31:0] got[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_issue = 0;
    int          last_issue_cyc = 0;
    bit          adder_on = 1'b1;
    bit          spur_gap = 1'b0;
    int          spur_req = 0;
    int          spur_ack = 0;
    int          cd = 0;
    int          rdy_left = 0;
    logic [31:0] resp = '0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    bit          prev_fv = 1'b0;
    bit          prev_ov = 1'b0;
    bit          prev_to = 1'b0;
    bit          prev_ordy = 1'b0;
    logic [31:0] prev_res = '0;

    always #5 clk = ~clk;

    fpu_add_issuer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .fpu_din1    (fpu_din1),
        .fpu_din2    (fpu_din2),
        .fpu_valid   (fpu_valid),
        .fpu_result  (fpu_result),
        .fpu_ready   (fpu_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_timeout (out_timeout),
        .busy        (busy)
    );

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Model, adder responder and per-cycle compare; inputs change at posedge+1, so negedge is quiet.
    initial begin
        res_t r;
        op_t  o;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                exp_ops.delete();
                exp_res.delete();
                cd = 0;
                rdy_left = 0;
                fpu_ready = 1'b0;
                fpu_result = '0;
                last_a = '0;
                last_b = '0;
                prev_fv = 1'b0;
                prev_ov = 1'b0;
                prev_to = 1'b0;
                prev_res = '0;
                prev_ordy = 1'b0;
                spur_ack = spur_req;
            end else begin
                if (prev_ov) begin
                    if (prev_ordy) begin
                        check_eq("out_clear", 32'(out_valid), 0);
                    end else begin
                        check_eq("out_hold", 32'(out_valid), 1);
                        check_eq("out_hold_res", out_result, prev_res);
                        check_eq("out_hold_to", 32'(out_timeout), 32'(prev_to));
                    end
                end else if (out_valid) begin
                    check_eq("out_expected", 32'(exp_res.size() > 0), 1);
                    if (exp_res.size() > 0) begin
                        r = exp_res.pop_front();
                        check_eq("out_time", cyc, r.due);
                        check_eq("out_result", out_result, r.r);
                        check_eq("out_timeout", 32'(out_timeout), 32'(r.to));
                        got.push_back(out_result);
                    end
                end
                if (exp_res.size() > 0 && cyc >= exp_res[0].due) begin
                    r = exp_res.pop_front();
                    bound_fail("out_missing");
                end

                if (rdy_left > 0) begin
                    rdy_left--;
                    if (rdy_left == 0) fpu_ready = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        fpu_ready = 1'b1;
                        fpu_result = resp;
                        rdy_left = spur_gap ? 2 : 1;
                        exp_res.push_back('{r: resp, to: 1'b0, due: cyc + 1});
                    end
                end
                if (spur_req != spur_ack) begin
                    spur_ack = spur_req;
                    fpu_ready = 1'b1;
                    rdy_left = 1;
                end

                if (fpu_valid) begin
                    n_issue++;
                    last_issue_cyc = cyc;
                    check_eq("fv_pulse", 32'(prev_fv), 0);
                    check_eq("fv_while_out", 32'(out_valid), 0);
                    check_eq("issue_expected", 32'(exp_ops.size() > 0), 1);
                    if (exp_ops.size() > 0) begin
                        o = exp_ops.pop_front();
                        check_eq("din1", fpu_din1, o.a);
                        check_eq("din2", fpu_din2, o.b);
                        last_a = o.a;
                        last_b = o.b;
                        if (adder_on) begin
                            cd = LAT;
                            resp = o.sum;
                        end else begin
                            exp_res.push_back('{r: FP32_QNAN, to: 1'b1, due: cyc + TO + 1});
                        end
                    end
                end else begin
                    check_eq("din1_hold", fpu_din1, last_a);
                    check_eq("din2_hold", fpu_din2, last_b);
                end

                check_eq("in_ready", 32'(in_ready), 32'(exp_ops.size() < DEPTH));
                if (in_valid && exp_ops.size() < DEPTH)
                    exp_ops.push_back('{a: in_a, b: in_b, sum: in_sum});

                prev_fv = fpu_valid;
                prev_ov = out_valid;
                prev_res = out_result;
                prev_to = out_timeout;
                prev_ordy = out_ready;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sum = s;
        step(1);
    endtask

    task automatic wait_out(input string name, input int lim);
        int k = 0;
        while (!out_valid && k < lim) begin
            step(1);
            k++;
        end
        if (!out_valid) bound_fail(name);
    endtask

    task automatic wait_idle(input string name, input int lim);
        int k = 0;
        while (!(exp_ops.size() == 0 && exp_res.size() == 0 && !busy && !out_valid
                 && cd == 0 && rdy_left == 0) && k < lim) begin
            step(1);
            k++;
        end
        if (k >= lim) bound_fail(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          rel;
        int          ng;
        logic [31:0] t2_exp [4];
        t2_exp[0] = 32'h40a00000;
        t2_exp[1] = 32'h40000000;
        t2_exp[2] = 32'h7f800000;
        t2_exp[3] = 32'h00000000;

        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_fpu_valid", 32'(fpu_valid), 0);
        check_eq("rst_din1", fpu_din1, 0);
        check_eq("rst_din2", fpu_din2, 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_timeout", 32'(out_timeout), 0);
        check_eq("rst_busy", 32'(busy), 0);
        step(2);
        reset = 1'b1;

        // 1: single op, result held until out_ready
        push(32'h3f800000, 32'h3f800000, 32'h40000000);
        in_valid = 1'b0;
        wait_out("t1_wait", 20);
        check_eq("t1_result", out_result, 32'h40000000);
        check_eq("t1_timeout", 32'(out_timeout), 0);
        check_eq("t1_issues", n_issue, 1);
        step(3);
        check_eq("t1_held", 32'(out_valid), 1);

        // 2: fill while the first result is still pending, fifth push dropped
        push(32'h40000000, 32'h40400000, 32'h40a00000);
        push(32'h3f800000, 32'h3f800000, 32'h40000000);
        push(32'h7f800000, 32'h3f800000, 32'h7f800000);
        push(32'hc0000000, 32'h40000000, 32'h00000000);
        check_eq("t2_full", 32'(in_ready), 0);
        push(32'h41200000, 32'h41200000, 32'h41a00000);
        in_valid = 1'b0;
        check_eq("t2_busy", 32'(busy), 1);
        check_eq("t2_no_issue", n_issue, 1);
        out_ready = 1'b1;
        wait_idle("t2_drain", 400);
        check_eq("t2_count", got.size(), 5);
        for (int i = 0; i < 4; i++)
            if (got.size() > i + 1) check_eq("t2_order", got[i + 1], t2_exp[i]);

        // 3: backpressure with two queued
        out_ready = 1'b0;
        push(32'h40000000, 32'h40000000, 32'h40800000);
        push(32'h3f800000, 32'h40000000, 32'h40400000);
        in_valid = 1'b0;
        wait_out("t3_wait", 20);
        base = n_issue;
        step(10);
        check_eq("t3_no_issue", n_issue, base);
        check_eq("t3_stable", out_result, 32'h40800000);
        check_eq("t3_busy", 32'(busy), 1);
        rel = cyc;
        out_ready = 1'b1;
        wait_idle("t3_drain", 100);
        check_eq("t3_issue_after", 32'(last_issue_cyc > rel), 1);
        check_eq("t3_count", got.size(), 7);
        if (got.size() == 7) begin
            check_eq("t3_res0", got[5], 32'h40800000);
            check_eq("t3_res1", got[6], 32'h40400000);
        end

        // 4: timeout, then a normal op
        adder_on = 1'b0;
        push(32'h3f800000, 32'h40000000, 32'h40400000);
        in_valid = 1'b0;
        wait_out("t4_wait", 100);
        check_eq("t4_qnan", out_result, 32'h7fc00000);
        check_eq("t4_timeout", 32'(out_timeout), 1);
        wait_idle("t4_idle", 20);
        adder_on = 1'b1;
        push(32'h40400000, 32'h3f800000, 32'h40800000);
        in_valid = 1'b0;
        wait_out("t4b_wait", 20);
        check_eq("t4b_result", out_result, 32'h40800000);
        check_eq("t4b_timeout", 32'(out_timeout), 0);
        wait_idle("t4b_idle", 20);

        // 5: spurious ready in IDLE and in GAP
        base = n_issue;
        ng = got.size();
        spur_req++;
        step(5);
        check_eq("t5_idle_ov", 32'(out_valid), 0);
        check_eq("t5_idle_busy", 32'(busy), 0);
        check_eq("t5_idle_issue", n_issue, base);
        spur_gap = 1'b1;
        push(32'h3f800000, 32'h3f800000, 32'h40000000);
        in_valid = 1'b0;
        wait_idle("t5_gap", 30);
        spur_gap = 1'b0;
        step(3);
        check_eq("t5_gap_count", got.size(), ng + 1);

        // 6: reset mid-WAIT with three queued, then mid-ISSUE
        adder_on = 1'b0;
        push(32'h3f800000, 32'h3f800000, 32'h40000000);
        push(32'h40000000, 32'h40000000, 32'h40800000);
        push(32'h40400000, 32'h40400000, 32'h40c00000);
        push(32'h40800000, 32'h40800000, 32'h41000000);
        in_valid = 1'b0;
        step(10);
        check_eq("t6_busy_pre", 32'(busy), 1);
        check_eq("t6_in_ready_pre", 32'(in_ready), 1);
        reset = 1'b0;
        #1;
        check_eq("t6_fpu_valid", 32'(fpu_valid), 0);
        check_eq("t6_out_valid", 32'(out_valid), 0);
        check_eq("t6_in_ready", 32'(in_ready), 1);
        check_eq("t6_busy", 32'(busy), 0);
        step(2);
        reset = 1'b1;
        adder_on = 1'b1;
        base = n_issue;
        step(100);
        check_eq("t6_no_issue", n_issue, base);
        check_eq("t6_no_out", 32'(out_valid), 0);
        check_eq("t6_idle", 32'(busy), 0);

        push(32'h3f800000, 32'h3f800000, 32'h40000000);
        in_valid = 1'b0;
        step(1);
        check_eq("t6b_pulse", 32'(fpu_valid), 1);
        reset = 1'b0;
        #1;
        check_eq("t6b_fv_drop", 32'(fpu_valid), 0);
        check_eq("t6b_din1", fpu_din1, 0);
        step(2);
        reset = 1'b1;
        step(20);
        check_eq("t6b_no_out", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
